// File: rtl/add_mul_pkg.sv
// Shared encodings for the sequential add/multiply unit.
package add_mul_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/shift_add_mul_step.sv
// One combinational shift-add iteration: conditional accumulate, then shift.
module shift_add_mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [2*WIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]   mplier_nxt
);
  // Partial product only when the current multiplier LSB is set.
  assign acc_nxt    = mplier[0] ? acc + mcand : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;
endmodule

// File: rtl/seq_add_mul_unit.sv
// Single-transaction add (1 cycle) / shift-add multiply (WIDTH cycles) unit
// with valid/ready on both sides.
module seq_add_mul_unit
  import add_mul_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);
  localparam int CW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]     mplier_nxt;
  logic [WIDTH:0]       sum;
  logic                 fire_in;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign fire_in = in_valid & in_ready;
  // acc doubles as the result register for both ops, so it is the output.
  assign result  = acc_q;

  shift_add_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; in_ready is masked while reset is held.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        busy     = 1'b0;
        in_ready = ~rst;
        if (in_valid && !rst) state_d = (op == OP_MUL) ? MUL : DONE;
      end
      MUL: begin
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, iterate in MUL, hold otherwise (incl. DONE).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (fire_in) begin
      if (op == OP_MUL) begin
        acc_q    <= '0;
        mcand_q  <= {{WIDTH{1'b0}}, a};
        mplier_q <= b;
        cnt_q    <= CNT_INIT;
      end else begin
        acc_q    <= {{(WIDTH-1){1'b0}}, sum};
      end
    end else if (state_q == MUL) begin
      acc_q    <= acc_nxt;
      mcand_q  <= mcand_nxt;
      mplier_q <= mplier_nxt;
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end
endmodule

// File: doc/seq_add_mul_unit.md
# seq_add_mul_unit

Parametrised sequential add/multiply unit for unsigned operands of WIDTH bits. Addition completes in one cycle. Multiplication uses an iterative shift-add datapath over WIDTH cycles. Transactions enter and leave through valid/ready handshakes, so the unit sits between an operand source and a result consumer on the design's single clock domain.

## Interface
- WIDTH, 4, operand width in bits (≥2); result width is 2*WIDTH.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- in_valid  in  1  operand transaction offered.
- in_ready  out  1  unit can accept a transaction.
- op  in  1  0 = add, 1 = multiply; sampled on input handshake.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  2*WIDTH  add: zero-extended {carry, sum}; mul: full product.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: in_ready=1.
  - MUL: iterating.
  - DONE: out_valid=1, result held.
- The input handshake fires when in_valid & in_ready. The unit captures a, b and op on that edge; it does not sample them in any other cycle.
- Add path: IDLE→DONE. result = a + b, zero-extended to 2*WIDTH; bit WIDTH is the carry and upper bits are 0.
- Mul path: IDLE→MUL.
  - Load mcand = a zero-extended to 2*WIDTH, mplier = b, acc = 0, cnt = WIDTH-1.
  - Each MUL cycle: if mplier[0], acc += mcand; then mcand <<= 1 and mplier >>= 1.
  - When cnt == 0 the final iteration is applied and the state goes to DONE; otherwise cnt decrements.
- Exactly WIDTH MUL cycles are always spent. There is no early exit on zero operands.
- DONE: result = acc (mul) or the sum (add), held stable. The output handshake (out_valid & out_ready) moves the state to IDLE.
- The unit holds one transaction at a time. in_ready=0 in MUL and in DONE.
- Arithmetic never overflows: the product fits in 2*WIDTH bits and the sum fits in WIDTH+1 bits.
- The op value is undefined only if X; it is treated as a 1-bit field, with no illegal encodings.

## Timing
- Reset values (asynchronous, immediate on rst rising edge):
  - state=IDLE, out_valid=0, result=0, busy=0, internal acc/mcand/mplier/cnt=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
- Add latency: handshake at edge N → out_valid=1 after edge N+1.
- Mul latency: handshake at edge N → out_valid=1 after edge N+WIDTH+1.
- result is valid and stable for the entire time out_valid=1. Its value in other cycles is don't-care, apart from the reset value.
- Output handshake at edge M → out_valid=0 and in_ready=1 after edge M. The next input is accepted at the earliest at edge M+1, so there is one bubble cycle between transactions.
- out_ready=0 holds DONE indefinitely with result unchanged.
- in_valid asserted while in_ready=0 is ignored; it is neither queued nor dropped with an error.
- Reset asserted mid-MUL or in DONE aborts the transaction with no output. After deassertion the unit behaves as freshly reset.
- out_ready high in IDLE or MUL has no effect.

## Structure
- Package add_mul_pkg holds:
  - op encoding constants OP_ADD=1'b0, OP_MUL=1'b1;
  - state typedef (IDLE, MUL, DONE), 2-bit encoding.
- One sub-module, shift_add_mul_step: a combinational single iteration that maps (acc, mcand, mplier) to their next values, parametrised by WIDTH.
- The top module holds the FSM, registers, counter of $clog2(WIDTH) bits (minimum 1) and handshake logic.

## Test plan
All scenarios use WIDTH=4.
- Add 7+9 (op=0), out_ready=1 → out_valid exactly one cycle after accept, result=8'h10, busy high for 1 cycle.
- Mul 15*15 (op=1), out_ready=1 → out_valid 5 cycles after accept, result=8'hE1; in_ready=0 throughout.
- Mul 0*13 and 13*0 → result=8'h00, with the same 5-cycle latency (no early exit).
- Backpressure: mul 6*7 with out_ready=0 for 10 cycles → result=8'h2A held stable. in_valid held high meanwhile is ignored. Releasing out_ready → in_ready=1 on the next cycle and the next operand is accepted one cycle later.
- Reset mid-multiply: assert rst during the 2nd MUL cycle of 9*11 → out_valid=0 and result=0 immediately. After release, add 3+4 gives result=8'h07 with normal latency.
- Random regression: 1000 mixed add/mul transactions with random in_valid/out_ready gaps; results compared against a + b and a * b in order, with no lost or duplicated transactions.
